tow_scorer: RTL and testbench
=============================

Name: tow_scorer

Overview:
- Game-state stage directly downstream of the push-button logic in the Tug-of-War design.
- Consumes push/tie/right and moves the "rope" LED one position per press, left or right.
- Detects a win, flashes the winning end LED and keeps per-player saturating round scores.
- Drives clr back to the push-button logic to release its latches once both buttons are up.

Parameters:
- POSITIONS, 7, number of LEDs; odd, >=3; centre index C=(POSITIONS-1)/2.
- FLASH_DIV, 25000000, clock cycles per half-period of the win flash; >=1.
- SCORE_W, 4, width of each score counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low (rst=0 resets).
- push  in  1  a press is latched upstream; already masked by clr.
- tie  in  1  both buttons are pressed.
- right  in  1  the press belongs to the right player.
- restart  in  1  synchronous new-round request, level, sampled each cycle.
- clr  out  1  registered one-cycle pulse that clears the upstream latches.
- leds  out  POSITIONS  rope display; leds[0]=left end, leds[POSITIONS-1]=right end.
- win_l  out  1  left player has won the current round.
- win_r  out  1  right player has won the current round.
- score_l  out  SCORE_W  left rounds won, saturating.
- score_r  out  SCORE_W  right rounds won, saturating.

Behaviour:
- Reset (rst=0, async) values:
  - pos=C, leds=one-hot bit C.
  - clr=0, win_l=win_r=0, score_l=score_r=0.
  - Handshake FSM=IDLE; flash counter=0; flash phase=on.
  - All input sample registers=0.
- Input stage: push/tie/right are registered once (push_q, tie_q, right_q); push_d = previous push_q.
- Event condition: push_q=1 and push_d=0, evaluated in IDLE only.
- Latency: push high before edge k -> event seen at edge k+1 -> new leds visible after edge k+1.
- Handshake FSM:
  - IDLE -> WAIT_REL on event.
  - WAIT_REL holds while push_q=1; moves to CLEAR when push_q=0.
  - CLEAR drives clr=1 for exactly one cycle, then returns to IDLE.
  - The handshake runs in all game states, including WIN.
- Move on event, only when win_l=win_r=0:
  - tie_q=1 -> no move.
  - else right_q=1 -> pos+1.
  - else pos-1.
- Win condition:
  - pos reaches POSITIONS-1 -> win_r=1, score_r+1 (saturate at 2^SCORE_W-1).
  - pos reaches 0 -> win_l=1, score_l+1 (saturate at 2^SCORE_W-1).
  - pos never leaves [0, POSITIONS-1].
- While a win is set:
  - Events cause no move; scores are frozen.
  - leds show only the winning end bit, gated by the flash phase. Phase starts on at win entry and toggles every FLASH_DIV cycles. Every other bit is 0.
- Restart (restart=1 on a clock edge):
  - pos=C, win flags cleared, flash phase reset to on.
  - Scores are held.
  - FSM goes to CLEAR from any state, giving one clr pulse.
  - Restart takes priority over a same-cycle event; that event is discarded.
  - A restart during play aborts the round with no score change.
- rst asserted mid-operation: immediate return to reset values, including clr=0 even mid-CLEAR.
- A new press arriving during CLEAR is masked by clr upstream; it is detected as a fresh edge once clr drops.

Test Plan:
- Reset: hold rst=0 with push=1 -> leds=7'b0001000, clr=0, scores=0, no move after rst releases while push is held? No: edge detect fires once push_q rises post-reset -> exactly one move.
- Right press: push=right=1 for 3 cycles, then 0 -> leds=7'b0010000 one edge after push_q rises; clr=1 for exactly one cycle after push_q falls; only one move.
- Tie: push=tie=right=1, then release -> leds stay 7'b0001000; one clr pulse.
- Left win: three left presses (FLASH_DIV=4) -> leds=7'b0000001, win_l=1, score_l=1; leds[0] toggles every 4 cycles; a 4th press gives no move but still one clr pulse.
- Restart in win: restart=1 for 1 cycle -> leds=7'b0001000, win_l=0, score_l stays 1, one clr pulse; restart coincident with an event -> no move.
- Saturation/abort: 16 right wins with SCORE_W=4 -> score_r=15 and holds. rst=0 during WAIT_REL -> all outputs at reset values within the same cycle; no clr pulse.

Source files
------------

// File: rtl/tow_scorer.sv
// Game-state stage for Tug-of-War.
// Moves the rope LED one step per press, detects a win, flashes the winning
// end, keeps saturating round scores and returns a clr pulse upstream once
// the buttons are released.
module tow_scorer #(
    parameter int POSITIONS = 7,
    parameter int FLASH_DIV = 25000000,
    parameter int SCORE_W   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic                 tie,
    input  logic                 right,
    input  logic                 restart,
    output logic                 clr,
    output logic [POSITIONS-1:0] leds,
    output logic                 win_l,
    output logic                 win_r,
    output logic [SCORE_W-1:0]   score_l,
    output logic [SCORE_W-1:0]   score_r
);

    localparam int PW = (POSITIONS > 1) ? $clog2(POSITIONS) : 1;
    localparam int CW = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;

    localparam logic [PW-1:0]      POS_C     = PW'((POSITIONS - 1) / 2);
    localparam logic [PW-1:0]      POS_MAX   = PW'(POSITIONS - 1);
    localparam logic [PW-1:0]      POS_ONE   = PW'(1);
    localparam logic [CW-1:0]      CNT_MAX   = CW'(FLASH_DIV - 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_REL = 2'd1,
        CLEAR    = 2'd2
    } hs_e;

    // input sample stage
    logic push_q, push_prev_q, tie_q, right_q;

    // handshake
    hs_e  state_q, state_d;
    logic clr_q;
    logic press_ev;

    // game state
    logic [PW-1:0]      pos_q, pos_d;
    logic               win_l_q, win_l_d;
    logic               win_r_q, win_r_d;
    logic [SCORE_W-1:0] score_l_q, score_l_d;
    logic [SCORE_W-1:0] score_r_q, score_r_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               phase_q, phase_d;

    // Register the upstream strobes once; push_prev_q gives the edge reference.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            push_q      <= 1'b0;
            push_prev_q <= 1'b0;
            tie_q       <= 1'b0;
            right_q     <= 1'b0;
        end else begin
            push_q      <= push;
            push_prev_q <= push_q;
            tie_q       <= tie;
            right_q     <= right;
        end
    end

    // A press counts only on a fresh rising edge while the handshake is idle.
    assign press_ev = (state_q == IDLE) && push_q && !push_prev_q;

    // Handshake state register plus registered clr (high exactly while in CLEAR).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            clr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            clr_q   <= (state_d == CLEAR);
        end
    end

    // Handshake next state: wait for release, then pulse clr once; restart forces a pulse.
    always_comb begin
        state_d = state_q;
        if (restart) begin
            state_d = CLEAR;
        end else begin
            case (state_q)
                IDLE:     if (press_ev) state_d = WAIT_REL;
                WAIT_REL: if (!push_q)  state_d = CLEAR;
                CLEAR:    state_d = IDLE;
                default:  state_d = IDLE;
            endcase
        end
    end

    // Game state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pos_q     <= POS_C;
            win_l_q   <= 1'b0;
            win_r_q   <= 1'b0;
            score_l_q <= '0;
            score_r_q <= '0;
            cnt_q     <= '0;
            phase_q   <= 1'b1;
        end else begin
            pos_q     <= pos_d;
            win_l_q   <= win_l_d;
            win_r_q   <= win_r_d;
            score_l_q <= score_l_d;
            score_r_q <= score_r_d;
            cnt_q     <= cnt_d;
            phase_q   <= phase_d;
        end
    end

    // Game next state: restart wins over everything, a won round only flashes,
    // otherwise a non-tie press moves the rope and may end the round.
    always_comb begin
        pos_d     = pos_q;
        win_l_d   = win_l_q;
        win_r_d   = win_r_q;
        score_l_d = score_l_q;
        score_r_d = score_r_q;
        cnt_d     = cnt_q;
        phase_d   = phase_q;
        if (restart) begin
            pos_d   = POS_C;
            win_l_d = 1'b0;
            win_r_d = 1'b0;
            cnt_d   = '0;
            phase_d = 1'b1;
        end else if (win_l_q || win_r_q) begin
            if (cnt_q == CNT_MAX) begin
                cnt_d   = '0;
                phase_d = !phase_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (press_ev && !tie_q) begin
            if (right_q) begin
                pos_d = pos_q + POS_ONE;
                if (pos_q + POS_ONE == POS_MAX) begin
                    win_r_d = 1'b1;
                    cnt_d   = '0;
                    phase_d = 1'b1;
                    if (score_r_q != SCORE_MAX) score_r_d = score_r_q + 1'b1;
                end
            end else begin
                pos_d = pos_q - POS_ONE;
                if (pos_q == POS_ONE) begin
                    win_l_d = 1'b1;
                    cnt_d   = '0;
                    phase_d = 1'b1;
                    if (score_l_q != SCORE_MAX) score_l_d = score_l_q + 1'b1;
                end
            end
        end
    end

    // Display: one-hot rope in play, flashing winner end bit after a win.
    always_comb begin
        leds = '0;
        if (win_l_q) begin
            leds[0] = phase_q;
        end else if (win_r_q) begin
            leds[POSITIONS-1] = phase_q;
        end else begin
            leds = POSITIONS'(1) << pos_q;
        end
    end

    assign clr     = clr_q;
    assign win_l   = win_l_q;
    assign win_r   = win_r_q;
    assign score_l = score_l_q;
    assign score_r = score_r_q;

endmodule

// File: tb/tb_tow_scorer.sv
// Bench for tow_scorer: reset, a vector table for the basic game flow,
// hand sequences for reset/saturation corners, and a randomized run
// against a cycle-level game model.
module tb_tow_scorer;

    localparam int P  = 7;
    localparam int FD = 4;
    localparam int SW = 4;
    localparam int C  = 3;
    localparam int SMAX = 15;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         push = 1'b0, tie = 1'b0, right = 1'b0, restart = 1'b0;
    logic         clr, win_l, win_r;
    logic [P-1:0] leds;
    logic [SW-1:0] score_l, score_r;

    int checks = 0;
    int errors = 0;

    tow_scorer #(.POSITIONS(P), .FLASH_DIV(FD), .SCORE_W(SW)) dut (
        .clk(clk), .rst(rst), .push(push), .tie(tie), .right(right),
        .restart(restart), .clr(clr), .leds(leds), .win_l(win_l),
        .win_r(win_r), .score_l(score_l), .score_r(score_r)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [P-1:0] e_leds, input logic e_clr,
                           input logic e_wl, input logic e_wr, input int e_sl, input int e_sr);
        chk({tag, ".leds"}, 32'(leds), 32'(e_leds));
        chk({tag, ".clr"}, 32'(clr), 32'(e_clr));
        chk({tag, ".win_l"}, 32'(win_l), 32'(e_wl));
        chk({tag, ".win_r"}, 32'(win_r), 32'(e_wr));
        chk({tag, ".score_l"}, 32'(score_l), 32'(e_sl));
        chk({tag, ".score_r"}, 32'(score_r), 32'(e_sr));
    endtask

    task automatic press(input logic r);
        push = 1'b1; right = r; step(); step();
        push = 1'b0; step(); step(); step();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic         p, t, r, rs;
        logic [P-1:0] leds;
        logic         clr, wl, wr;
        int           sl, sr;
    } vec_t;

    vec_t tv[$];

    task automatic row(input logic p, input logic t, input logic r, input logic rs,
                       input logic [P-1:0] l, input logic c, input logic wl, input logic wr,
                       input int sl, input int sr);
        vec_t v;
        v.p = p; v.t = t; v.r = r; v.rs = rs;
        v.leds = l; v.clr = c; v.wl = wl; v.wr = wr; v.sl = sl; v.sr = sr;
        tv.push_back(v);
    endtask

    // ---------------- behavioural game model ----------------
    int m_pos, m_win, m_sl, m_sr, m_hs, m_age;   // m_win: 0 none, 1 left, 2 right
    bit m_p1, m_p2, m_t, m_r, m_clr;             // m_hs: 0 idle, 1 waiting release, 2 clearing

    task automatic model_reset();
        m_pos = C; m_win = 0; m_sl = 0; m_sr = 0; m_hs = 0; m_age = 0;
        m_p1 = 0; m_p2 = 0; m_t = 0; m_r = 0; m_clr = 0;
    endtask

    task automatic model_edge(input bit p, input bit t, input bit r, input bit rs);
        bit ev;
        int nhs;
        ev = (m_hs == 0) && m_p1 && !m_p2;
        if (rs)             nhs = 2;
        else if (m_hs == 0) nhs = ev ? 1 : 0;
        else if (m_hs == 1) nhs = m_p1 ? 1 : 2;
        else                nhs = 0;
        if (rs) begin
            m_pos = C; m_win = 0; m_age = 0;
        end else if (m_win != 0) begin
            m_age++;
        end else if (ev && !m_t) begin
            m_pos += m_r ? 1 : -1;
            if (m_pos == P - 1) begin
                m_win = 2; m_age = 0; m_sr = (m_sr < SMAX) ? m_sr + 1 : SMAX;
            end else if (m_pos == 0) begin
                m_win = 1; m_age = 0; m_sl = (m_sl < SMAX) ? m_sl + 1 : SMAX;
            end
        end
        m_hs = nhs;
        m_clr = (nhs == 2);
        m_p2 = m_p1; m_p1 = p; m_t = t; m_r = r;
    endtask

    function automatic logic [P-1:0] model_leds();
        logic [P-1:0] one;
        one = 1;
        if (m_win == 0) return one << m_pos;
        if (((m_age / FD) % 2) != 0) return '0;
        return (m_win == 1) ? one : (one << (P - 1));
    endfunction

    // ---------------- test sequence ----------------
    initial begin
        logic [P-1:0] lc;
        bit raw;
        lc = 1;

        // Reset held with push high: nothing moves while in reset.
        rst = 1'b0; push = 1'b1; right = 1'b0;
        step(); step(); step();
        chk_all("reset", 7'b0001000, 0, 0, 0, 0, 0);

        // Release with push still held: exactly one move, clr only after release.
        rst = 1'b1;
        step();
        chk("rst_rel.e1.leds", 32'(leds), 32'(7'b0001000));
        step();
        chk("rst_rel.e2.leds", 32'(leds), 32'(7'b0000100));
        repeat (4) step();
        chk("rst_rel.held.leds", 32'(leds), 32'(7'b0000100));
        chk("rst_rel.held.clr", 32'(clr), 0);
        push = 1'b0; step();
        chk("rst_rel.r1.clr", 32'(clr), 0);
        step();
        chk("rst_rel.r2.clr", 32'(clr), 1);
        step();
        chk("rst_rel.r3.clr", 32'(clr), 0);
        restart = 1'b1; step();
        chk_all("restart0", 7'b0001000, 1, 0, 0, 0, 0);
        restart = 1'b0; step();
        chk("restart0.clr_end", 32'(clr), 0);

        // Table: right press, tie, four left presses to a win, press during win,
        // restart in win, restart coincident with an event.
        row(1,0,1,0, 7'b0001000,0,0,0,0,0);
        row(1,0,1,0, 7'b0010000,0,0,0,0,0);
        row(1,0,1,0, 7'b0010000,0,0,0,0,0);
        row(0,0,0,0, 7'b0010000,0,0,0,0,0);
        row(0,0,0,0, 7'b0010000,1,0,0,0,0);
        row(0,0,0,0, 7'b0010000,0,0,0,0,0);
        row(1,1,1,0, 7'b0010000,0,0,0,0,0);
        row(1,1,1,0, 7'b0010000,0,0,0,0,0);
        row(0,0,0,0, 7'b0010000,0,0,0,0,0);
        row(0,0,0,0, 7'b0010000,1,0,0,0,0);
        row(0,0,0,0, 7'b0010000,0,0,0,0,0);
        for (int k = 4; k > 1; k--) begin
            row(1,0,0,0, lc << k,       0,0,0,0,0);
            row(1,0,0,0, lc << (k - 1), 0,0,0,0,0);
            row(0,0,0,0, lc << (k - 1), 0,0,0,0,0);
            row(0,0,0,0, lc << (k - 1), 1,0,0,0,0);
            row(0,0,0,0, lc << (k - 1), 0,0,0,0,0);
        end
        row(1,0,0,0, 7'b0000010,0,0,0,0,0);
        row(1,0,0,0, 7'b0000001,0,1,0,1,0);
        row(0,0,0,0, 7'b0000001,0,1,0,1,0);
        row(0,0,0,0, 7'b0000001,1,1,0,1,0);
        row(0,0,0,0, 7'b0000001,0,1,0,1,0);
        row(1,0,0,0, 7'b0000000,0,1,0,1,0);
        row(1,0,0,0, 7'b0000000,0,1,0,1,0);
        row(0,0,0,0, 7'b0000000,0,1,0,1,0);
        row(0,0,0,0, 7'b0000000,1,1,0,1,0);
        row(0,0,0,0, 7'b0000001,0,1,0,1,0);
        row(0,0,0,1, 7'b0001000,1,0,0,1,0);
        row(0,0,0,0, 7'b0001000,0,0,0,1,0);
        row(1,0,0,0, 7'b0001000,0,0,0,1,0);
        row(1,0,0,1, 7'b0001000,1,0,0,1,0);
        row(1,0,0,0, 7'b0001000,0,0,0,1,0);
        row(0,0,0,0, 7'b0001000,0,0,0,1,0);
        row(0,0,0,0, 7'b0001000,0,0,0,1,0);
        foreach (tv[i]) begin
            push = tv[i].p; tie = tv[i].t; right = tv[i].r; restart = tv[i].rs;
            step();
            chk_all($sformatf("vec%0d", i), tv[i].leds, tv[i].clr, tv[i].wl, tv[i].wr,
                    tv[i].sl, tv[i].sr);
        end
        push = 0; tie = 0; right = 0; restart = 0;

        // Async reset while waiting for release: immediate reset values, no clr afterwards.
        push = 1'b1; right = 1'b1; step(); step(); step();
        chk("wait_rel.leds", 32'(leds), 32'(7'b0010000));
        #3 rst = 1'b0;
        #1 chk_all("async_rst", 7'b0001000, 0, 0, 0, 0, 0);
        push = 1'b0; right = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("async_rst.hold.clr", 32'(clr), 0);
        end
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("post_rst.clr", 32'(clr), 0);
        end
        chk("post_rst.leds", 32'(leds), 32'(7'b0001000));

        // Sixteen right wins: score saturates at 15.
        for (int i = 0; i < 16; i++) begin
            press(1); press(1); press(1);
            chk("sat.win_r", 32'(win_r), 1);
            chk("sat.leds", 32'(leds), 32'(7'b1000000));
            chk("sat.score_r", 32'(score_r), (i + 1 < SMAX) ? i + 1 : SMAX);
            restart = 1'b1; step(); restart = 1'b0; step();
        end
        chk("sat.final", 32'(score_r), SMAX);
        chk("sat.score_l", 32'(score_l), 0);

        // Randomized play against the model.
        rst = 1'b0; step(); rst = 1'b1;
        model_reset();
        raw = 0;
        for (int n = 0; n < 3000; n++) begin
            logic [P-1:0] el;
            if ($urandom_range(5) == 0) raw = !raw;
            push    = raw && !clr;
            tie     = ($urandom_range(5) == 0);
            right   = $urandom_range(1);
            restart = ($urandom_range(60) == 0);
            model_edge(push, tie, right, restart);
            step();
            el = model_leds();
            chk($sformatf("rand%0d", n),
                {16'(leds), 1'b0, clr, win_l, win_r, 4'(score_l), 4'(score_r), 4'h0},
                {16'(el), 1'b0, m_clr, m_win == 1, m_win == 2, 4'(m_sl), 4'(m_sr), 4'h0});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
